// File: rtl/branch_resolve_ctrl_if.sv
// Fetch/execute <-> branch resolve controller bundle.
// BP_STATS_EN adds the predictor statistics counters.
interface branch_resolve_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push;
    logic [15:0]   push_pc;
    logic          push_pred;
    logic [15:0]   push_target;
    logic          resolve;
    logic          resolve_taken;
    logic [15:0]   resolve_target;
    logic          load_BR;
    logic          BR_taken;
    logic [15:0]   idex_PC;
    logic          flush;
    logic          redirect_valid;
    logic [15:0]   redirect_pc;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
`ifdef BP_STATS_EN
    logic [15:0]   stat_resolved;
    logic [15:0]   stat_mispredict;
`endif

    modport master (
        output push, push_pc, push_pred, push_target,
        output resolve, resolve_taken, resolve_target,
        input  load_BR, BR_taken, idex_PC,
        input  flush, redirect_valid, redirect_pc,
        input  full, empty, count
`ifdef BP_STATS_EN
        , input stat_resolved, stat_mispredict
`endif
    );

    modport slave (
        input  push, push_pc, push_pred, push_target,
        input  resolve, resolve_taken, resolve_target,
        output load_BR, BR_taken, idex_PC,
        output flush, redirect_valid, redirect_pc,
        output full, empty, count
`ifdef BP_STATS_EN
        , output stat_resolved, stat_mispredict
`endif
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// In-order branch queue: predictor update, flush and PC redirect on mispredict.
// BP_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_ctrl #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    branch_resolve_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t state, state_nx;

    logic [15:0]   pc_q  [DEPTH];
    logic [15:0]   tgt_q [DEPTH];
    logic          pred_q[DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [FW-1:0] fcnt;

    logic          load_br_r, br_taken_r, redir_r;
    logic [15:0]   idex_pc_r, redir_pc_r;

    logic          full, empty;
    logic          do_res, do_push, mis;
    logic [15:0]   h_pc, h_tgt, rpc;
    logic          h_pred;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign h_pc    = pc_q[head];
    assign h_tgt   = tgt_q[head];
    assign h_pred  = pred_q[head];

    assign do_res  = state == RUN && bus.resolve && !empty;
    assign mis     = do_res &&
                     (h_pred != bus.resolve_taken ||
                      (h_pred && h_tgt != bus.resolve_target));
    // a push may take the slot freed by a same-cycle correct resolve
    assign do_push = state == RUN && bus.push && !mis &&
                     (!full || do_res);
    assign rpc     = bus.resolve_taken ? bus.resolve_target
                                       : h_pc + 16'd2;

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:   if (mis) state_nx = FLUSH;
            FLUSH: if (fcnt == '0) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fcnt <= '0;
        end else if (mis) begin
            fcnt <= FW'(FLUSH_CYCLES - 1);
        end else if (state == FLUSH && fcnt != '0) begin
            fcnt <= fcnt - FW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mis) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_res)  head <= head + AW'(1);
            if (do_push) tail <= tail + AW'(1);
            if (do_push && !do_res)      count <= count + CW'(1);
            else if (do_res && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_q[tail]   <= bus.push_pc;
            tgt_q[tail]  <= bus.push_target;
            pred_q[tail] <= bus.push_pred;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_br_r  <= 1'b0;
            br_taken_r <= 1'b0;
            idex_pc_r  <= 16'h0000;
            redir_r    <= 1'b0;
            redir_pc_r <= 16'h0000;
        end else begin
            load_br_r <= do_res;
            redir_r   <= mis;
            if (do_res) begin
                br_taken_r <= bus.resolve_taken;
                idex_pc_r  <= h_pc;
            end
            if (mis) redir_pc_r <= rpc;
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] st_res, st_mis;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_res <= '0;
            st_mis <= '0;
        end else begin
            if (do_res && st_res != 16'hFFFF) st_res <= st_res + 16'd1;
            if (mis && st_mis != 16'hFFFF)    st_mis <= st_mis + 16'd1;
        end
    end

    assign bus.stat_resolved   = st_res;
    assign bus.stat_mispredict = st_mis;
`endif

    assign bus.load_BR        = load_br_r;
    assign bus.BR_taken       = br_taken_r;
    assign bus.idex_PC        = idex_pc_r;
    assign bus.flush          = state == FLUSH;
    assign bus.redirect_valid = redir_r;
    assign bus.redirect_pc    = redir_pc_r;
    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.count          = count;
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequencer that sits between fetch, execute and the PC-indexed 2-bit branch predictor.
- Records every predicted branch leaving fetch in an in-order queue.
- When execute resolves the oldest branch, it drives the predictor's update strobe, taken bit and update PC.
- On a misprediction, it issues a pipeline flush and a PC redirect.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of 2, minimum 2.
- FLUSH_CYCLES, 2, number of cycles `flush` stays high after a misprediction; minimum 1.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- push  in  1  fetch issues a predicted branch this cycle
- push_pc  in  16  PC of that branch
- push_pred  in  1  predicted direction (1 = taken)
- push_target  in  16  predicted target address
- resolve  in  1  execute resolves the oldest in-flight branch this cycle
- resolve_taken  in  1  actual direction
- resolve_target  in  16  actual target address
- load_BR  out  1  predictor update strobe
- BR_taken  out  1  actual direction, sent to the predictor
- idex_PC  out  16  PC of the branch being updated
- flush  out  1  squash younger instructions
- redirect_valid  out  1  one-cycle pulse: load `redirect_pc` into the PC
- redirect_pc  out  16  corrected fetch address
- full  out  1  queue holds DEPTH entries; fetch must stall
- empty  out  1  queue holds 0 entries
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: asynchronous, active-low; clk is the only clock.
  - Queue is emptied; count=0, empty=1, full=0.
  - load_BR, BR_taken, flush and redirect_valid are 0.
  - idex_PC and redirect_pc are 16'h0000.
  - State is RUN.
  - Reset asserted mid-flush aborts the flush immediately.
- Queue: circular FIFO with head and tail pointers that wrap modulo DEPTH.
  - Each entry holds {pc, pred, target}.
  - full and empty are combinational from count.
- States: RUN and FLUSH.
- RUN, push:
  - Accepted only when !full, or when full and a resolve occurs in the same cycle (the pop frees a slot).
  - A push to a full queue with no resolve is dropped silently.
- RUN, resolve:
  - Ignored when the queue is empty: no pop, no load_BR.
  - Otherwise, the head entry is compared at cycle N.
  - Mispredict when pred != resolve_taken, or when both are taken and target != resolve_target.
- Outputs for a resolve at cycle N appear registered at cycle N+1:
  - load_BR=1 for exactly one cycle.
  - BR_taken = resolve_taken.
  - idex_PC = head pc.
  - The head entry is popped at edge N.
- Correct prediction: no flush; a simultaneous push at N is accepted normally.
- Mispredict:
  - At edge N the whole queue is cleared (count=0). Any push at N is dropped.
  - From cycle N+1: redirect_valid=1 for exactly one cycle.
  - redirect_pc = resolve_target if taken, else head pc + 16'd2, computed with mod-2^16 wrap.
  - flush=1 for cycles N+1 through N+FLUSH_CYCLES.
  - The state machine enters FLUSH.
- FLUSH:
  - push and resolve are ignored; no load_BR is issued.
  - An internal down-counter runs to zero, then the state returns to RUN.
  - The first push can be accepted at cycle N+FLUSH_CYCLES+1.
- idex_PC, BR_taken and redirect_pc hold their last values between pulses.

Optional Feature:
- BP_STATS_EN defined:
  - Adds outputs stat_resolved[15:0] and stat_mispredict[15:0].
  - Each counts the resolves accepted and the mispredicts respectively.
  - Both increment in the cycle load_BR is asserted, saturate at 16'hFFFF, and are cleared by reset.
- BP_STATS_EN undefined: neither port nor counter exists.

Test Plan:
- Reset, then push pc=0x0100 pred=1 target=0x0120, then resolve taken=1 target=0x0120 -> next cycle load_BR=1, BR_taken=1, idex_PC=0x0100; flush=0; count returns to 0.
- Push pc=0x0200 pred=1, then resolve taken=0 -> load_BR=1, BR_taken=0, redirect_valid=1 with redirect_pc=0x0202; flush high for 2 cycles; pushes during those cycles are dropped (count stays 0).
- Push pc=0x0300 pred=1 target=0x0340, then resolve taken=1 target=0x0360 -> mispredict; redirect_pc=0x0360.
- Push 4 entries -> full=1; a 5th push alone is dropped (count=4); push+resolve together (correct prediction) -> count stays 4 and the head advances in order; pointers wrap over 10 cycles with FIFO order preserved.
- Resolve with the queue empty -> load_BR stays 0 and count stays 0; push pc=0xFFFE pred=1, resolve taken=0 -> redirect_pc=0x0000.
- Assert reset_n=0 during the second flush cycle -> flush, redirect_valid and count clear immediately; with BP_STATS_EN, both counters read 0 after reset and count 3 resolves / 1 mispredict after the corresponding stimulus.
